// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDSR1     = 8'h05;
  localparam logic [7:0] CMD_JEDEC     = 8'h9F;

  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ID,
    STAT,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Brings nCS/CLK/MOSI into the MCLK domain and turns SPI clock edges into
// single-cycle rise/fall pulses. Edge pulses are suppressed while the
// synchronised chip select is high.
module spi_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic ncs,
  input  logic sck,
  input  logic mosi,
  output logic ncs_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall
);

  logic ncs_meta;
  logic sck_meta;
  logic sck_sync;
  logic sck_prev;
  logic mosi_meta;

  // two-flop synchronisers plus one history flop on the serial clock
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_meta  <= 1'b1;
      ncs_sync  <= 1'b1;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      ncs_meta  <= ncs;
      ncs_sync  <= ncs_meta;
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev & ~ncs_sync;
  assign sck_fall = ~sck_sync & sck_prev & ~ncs_sync;

endmodule

// File: rtl/spi_flash_responder.sv
// Read-only SPI mode-0 flash stand-in serving bytes from a ROM read port.
// Optional macro FAST_READ_EN enables command 0x0B (24 address bits, 8 dummy
// clocks, then the same stream as 0x03).
//
// state  | meaning
// IDLE   | waiting for chip select to fall
// CMD    | shifting in the 8-bit command
// ADDR   | shifting in the 24-bit address (low bits land in ROMADDR)
// DUMMY  | counting 8 dummy clocks of a fast read
// DATA   | streaming ROM bytes, prefetching one byte ahead
// ID     | streaming the JEDEC ID, then zeros
// STAT   | streaming status register (always zero)
// IGNORE | unknown command, stay silent until chip select rises
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
  input  logic                  MCLK,
  input  logic                  RST,
  input  logic                  nCS,
  input  logic                  CLK,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISOEN,
  output logic [ADDR_WIDTH-1:0] ROMADDR,
  output logic                  ROMRD,
  input  logic [7:0]            ROMDATA,
  output logic [7:0]            LASTCMD,
  output logic                  ACTIVE
);

  logic       ncs_s;
  logic       mosi_s;
  logic       sck_rise;
  logic       sck_fall;

  state_t     state;
  logic [4:0] bit_cnt;
  logic [2:0] out_cnt;
  logic [6:0] cmd_sr;
  logic [7:0] cmd_byte;
  logic [7:0] shift_out;
  logic [7:0] nxt_byte;
  logic [1:0] id_idx;
  logic       rd_pending;

  spi_input_sync u_sync (
    .clk      (MCLK),
    .rst      (RST),
    .ncs      (nCS),
    .sck      (CLK),
    .mosi     (MOSI),
    .ncs_sync (ncs_s),
    .mosi_sync(mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign cmd_byte = {cmd_sr, mosi_s};

  // protocol FSM, shift registers and ROM prefetch
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      out_cnt    <= '0;
      cmd_sr     <= '0;
      shift_out  <= '0;
      nxt_byte   <= '0;
      id_idx     <= '0;
      rd_pending <= 1'b0;
      MISO       <= 1'b0;
      MISOEN     <= 1'b0;
      ROMRD      <= 1'b0;
      ROMADDR    <= '0;
      LASTCMD    <= 8'h00;
      ACTIVE     <= 1'b0;
    end else begin
      ROMRD      <= 1'b0;
      rd_pending <= ROMRD;
      if (rd_pending) nxt_byte <= ROMDATA;

      if (ncs_s) begin
        state  <= IDLE;
        MISOEN <= 1'b0;
        ACTIVE <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
            out_cnt <= '0;
          end
          CMD: if (sck_rise) begin
            cmd_sr  <= cmd_byte[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              LASTCMD <= cmd_byte;
              case (cmd_byte)
                CMD_READ: state <= ADDR;
`ifdef FAST_READ_EN
                CMD_FAST_READ: state <= ADDR;
`endif
                CMD_JEDEC: begin
                  state    <= ID;
                  ACTIVE   <= 1'b1;
                  nxt_byte <= JEDEC_ID[23:16];
                  id_idx   <= 2'd1;
                end
                CMD_RDSR1: begin
                  state    <= STAT;
                  ACTIVE   <= 1'b1;
                  nxt_byte <= 8'h00;
                end
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (sck_rise) begin
            // address shifts straight into ROMADDR; bits above ADDR_WIDTH fall off the top
            ROMADDR <= {ROMADDR[ADDR_WIDTH-2:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(ADDR_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef FAST_READ_EN
              if (LASTCMD == CMD_FAST_READ) begin
                state <= DUMMY;
              end else
`endif
              begin
                ROMRD  <= 1'b1;
                state  <= DATA;
                ACTIVE <= 1'b1;
              end
            end
          end
`ifdef FAST_READ_EN
          DUMMY: if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(DUMMY_BITS - 1)) begin
              bit_cnt <= '0;
              ROMRD   <= 1'b1;
              state   <= DATA;
              ACTIVE  <= 1'b1;
            end
          end
`endif
          DATA: if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            // mid-byte prefetch leaves ample time before the next byte boundary
            if (bit_cnt[2:0] == 3'd3) begin
              ROMADDR <= ROMADDR + ADDR_WIDTH'(1);
              ROMRD   <= 1'b1;
            end
          end
          ID, STAT, IGNORE: ;
          default: state <= IDLE;
        endcase

        if (sck_fall && (state == DATA || state == ID || state == STAT)) begin
          MISOEN  <= 1'b1;
          out_cnt <= out_cnt + 3'd1;
          if (out_cnt == 3'd0) begin
            MISO      <= nxt_byte[7];
            shift_out <= {nxt_byte[6:0], 1'b0};
            if (state == ID) begin
              case (id_idx)
                2'd1:    begin nxt_byte <= JEDEC_ID[15:8]; id_idx <= 2'd2; end
                2'd2:    begin nxt_byte <= JEDEC_ID[7:0];  id_idx <= 2'd3; end
                default: nxt_byte <= 8'h00;
              endcase
            end
          end else begin
            MISO      <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a bit-banged SPI master, a ROM
// model with one-cycle read latency, and a log of every ROMRD address.
module tb_spi_flash_responder;

  localparam int HALF = 80;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        ncs = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        misoen;
  logic        romrd;
  logic        active;
  logic [14:0] romaddr;
  logic [7:0]  romdata;
  logic [7:0]  lastcmd;
  logic [7:0]  rom [0:32767];
  logic [14:0] rd_log [$];
  logic [7:0]  rx;
  int          total = 0;
  int          bad = 0;

  always #5 mclk = ~mclk;

  spi_flash_responder #(.ADDR_WIDTH(15), .JEDEC_ID(24'hEF4016)) dut (
    .MCLK(mclk), .RST(rst), .nCS(ncs), .CLK(sck), .MOSI(mosi),
    .MISO(miso), .MISOEN(misoen), .ROMADDR(romaddr), .ROMRD(romrd),
    .ROMDATA(romdata), .LASTCMD(lastcmd), .ACTIVE(active)
  );

  always @(posedge mclk) if (romrd) romdata <= rom[romaddr];

  always @(negedge mclk) if (romrd) rd_log.push_back(romaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #HALF;
      r = {r[6:0], miso};
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_start();
    @(negedge mclk);
    rd_log.delete();
    ncs = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF;
    ncs = 1'b1;
    #(4*HALF);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 8'hEE;
    rom[15'h03FA] = 8'hA5;
    rom[15'h03FB] = 8'h3C;
    rom[15'h7FFF] = 8'h81;
    rom[15'h0000] = 8'h42;
    rom[15'h0001] = 8'h99;
    rom[15'h0010] = 8'h5A;
    rom[15'h0100] = 8'hC3;

    // reset values
    repeat (5) @(negedge mclk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_misoen", {31'd0, misoen}, 32'd0);
    chk("rst_romrd", {31'd0, romrd}, 32'd0);
    chk("rst_romaddr", {17'd0, romaddr}, 32'd0);
    chk("rst_lastcmd", {24'd0, lastcmd}, 32'h00);
    chk("rst_active", {31'd0, active}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge mclk);

    // plain read from 0x3FA
    cs_start();
    spi_byte(8'h03, rx);
    chk("rd_misoen_cmd", {31'd0, misoen}, 32'd0);
    spi_byte(8'h00, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'hFA, rx);
    spi_byte(8'h00, rx);
    chk("rd_byte0", {24'd0, rx}, 32'hA5);
    spi_byte(8'h00, rx);
    chk("rd_byte1", {24'd0, rx}, 32'h3C);
    chk("rd_lastcmd", {24'd0, lastcmd}, 32'h03);
    chk("rd_active", {31'd0, active}, 32'd1);
    chk("rd_misoen", {31'd0, misoen}, 32'd1);
    chk("rd_nreads", rd_log.size(), 32'd3);
    chk("rd_addr0", {17'd0, rd_log[0]}, 32'h3FA);
    chk("rd_addr1", {17'd0, rd_log[1]}, 32'h3FB);
    chk("rd_addr2", {17'd0, rd_log[2]}, 32'h3FC);
    cs_end();
    chk("rd_end_misoen", {31'd0, misoen}, 32'd0);

    // address wrap from 0x7FFF
    cs_start();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h7F, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'h00, rx);
    chk("wrap_byte0", {24'd0, rx}, 32'h81);
    spi_byte(8'h00, rx);
    chk("wrap_byte1", {24'd0, rx}, 32'h42);
    spi_byte(8'h00, rx);
    chk("wrap_byte2", {24'd0, rx}, 32'h99);
    chk("wrap_addr1", {17'd0, rd_log[1]}, 32'h0000);
    chk("wrap_addr2", {17'd0, rd_log[2]}, 32'h0001);
    cs_end();

    // JEDEC ID
    cs_start();
    spi_byte(8'h9F, rx);
    chk("id_lastcmd", {24'd0, lastcmd}, 32'h9F);
    spi_byte(8'h00, rx);
    chk("id_byte0", {24'd0, rx}, 32'hEF);
    chk("id_active0", {31'd0, active}, 32'd1);
    spi_byte(8'h00, rx);
    chk("id_byte1", {24'd0, rx}, 32'h40);
    chk("id_active1", {31'd0, active}, 32'd1);
    spi_byte(8'h00, rx);
    chk("id_byte2", {24'd0, rx}, 32'h16);
    chk("id_active2", {31'd0, active}, 32'd1);
    spi_byte(8'h00, rx);
    chk("id_byte3", {24'd0, rx}, 32'h00);
    chk("id_active3", {31'd0, active}, 32'd1);
    chk("id_misoen_on", {31'd0, misoen}, 32'd1);
    ncs = 1'b1;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("id_misoen_off", {31'd0, misoen}, 32'd0);
    chk("id_active_off", {31'd0, active}, 32'd0);
    #(4*HALF);

    // unknown command
    cs_start();
    spi_byte(8'hAB, rx);
    spi_byte(8'h00, rx);
    chk("unk_misoen0", {31'd0, misoen}, 32'd0);
    spi_byte(8'hFF, rx);
    chk("unk_misoen1", {31'd0, misoen}, 32'd0);
    chk("unk_active", {31'd0, active}, 32'd0);
    chk("unk_lastcmd", {24'd0, lastcmd}, 32'hAB);
    cs_end();
    chk("unk_nreads", rd_log.size(), 32'd0);

    // status register
    cs_start();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    chk("stat_byte0", {24'd0, rx}, 32'h00);
    spi_byte(8'h00, rx);
    chk("stat_byte1", {24'd0, rx}, 32'h00);
    chk("stat_misoen", {31'd0, misoen}, 32'd1);
    chk("stat_active", {31'd0, active}, 32'd1);
    chk("stat_lastcmd", {24'd0, lastcmd}, 32'h05);
    cs_end();

    // abort after 12 address bits, then a clean read of 0x10
    cs_start();
    spi_byte(8'h03, rx);
    spi_byte(8'hFF, rx);
    spi_bits(8'hF0, 4, rx);
    chk("abort_misoen", {31'd0, misoen}, 32'd0);
    cs_end();
    chk("abort_nreads", rd_log.size(), 32'd0);
    cs_start();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h00, rx);
    chk("abort_byte", {24'd0, rx}, 32'h5A);
    chk("abort_addr0", {17'd0, rd_log[0]}, 32'h010);
    cs_end();

    // synchronous reset in the middle of a data stream
    cs_start();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h03, rx);
    spi_byte(8'hFA, rx);
    spi_byte(8'h00, rx);
    spi_bits(8'h00, 3, rx);
    #HALF;
    chk("mid_miso_pre", {31'd0, miso}, 32'd1);
    chk("mid_addr_pre", {17'd0, romaddr}, 32'h3FB);
    @(negedge mclk);
    rst = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    chk("mid_miso", {31'd0, miso}, 32'd0);
    chk("mid_misoen", {31'd0, misoen}, 32'd0);
    chk("mid_romrd", {31'd0, romrd}, 32'd0);
    chk("mid_romaddr", {17'd0, romaddr}, 32'd0);
    chk("mid_lastcmd", {24'd0, lastcmd}, 32'h00);
    chk("mid_active", {31'd0, active}, 32'd0);
    ncs = 1'b1;
    repeat (4) @(negedge mclk);
    rst = 1'b0;
    #(4*HALF);

    // fast read 0B 00 01 00 + 8 dummy clocks
    cs_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    chk("fast_lastcmd", {24'd0, lastcmd}, 32'h0B);
`ifdef FAST_READ_EN
    chk("fast_byte0", {24'd0, rx}, 32'hC3);
    chk("fast_misoen", {31'd0, misoen}, 32'd1);
    chk("fast_addr0", {17'd0, rd_log[0]}, 32'h100);
`else
    chk("fast_misoen", {31'd0, misoen}, 32'd0);
    chk("fast_active", {31'd0, active}, 32'd0);
    chk("fast_nreads", rd_log.size(), 32'd0);
`endif
    cs_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI mode-0 flash responder that emulates the read subset of a W25Q32-class serial flash. It serves image bytes from an on-chip ROM/BRAM read port.
- It sits on the same nCS/CLK/MOSI/MISO pins that SPILoader drives. This lets the loader be exercised on hardware and in simulation without the vendor flash model, and lets the FPGA act as a flash stand-in.
- All SPI inputs are oversampled in the MCLK domain.

Parameters:
- ADDR_WIDTH, 15: ROM byte-address width. The low ADDR_WIDTH bits of the 24-bit SPI address are used; upper bits are ignored.
- JEDEC_ID, 24'hEF4016: three bytes returned by command 0x9F, MSB first.

Ports:
- MCLK  in  1  system clock; must run at least 8x the SPI CLK frequency.
- RST  in  1  synchronous active-high reset.
- nCS  in  1  SPI chip select, active low.
- CLK  in  1  SPI serial clock, idle low (mode 0).
- MOSI  in  1  SPI data from the master.
- MISO  out  1  SPI data to the master.
- MISOEN  out  1  MISO output enable; the top level tri-states MISO when this is low.
- ROMADDR  out  ADDR_WIDTH  ROM byte address.
- ROMRD  out  1  one-cycle ROM read strobe.
- ROMDATA  in  8  ROM read data, valid exactly 1 MCLK after ROMRD.
- LASTCMD  out  8  most recently decoded command byte.
- ACTIVE  out  1  high while a recognised command is being served.

Behaviour:
- Input sampling:
  - nCS, CLK and MOSI each pass through a 2-flop synchroniser.
  - A rising or falling SCK event is a one-MCLK pulse derived from the synchronised CLK against its previous value.
  - Events are ignored while synchronised nCS is high.
- SPI timing: MOSI is sampled on rise events. MISO is updated on fall events, MSB first.
- Reset values: MISO=0, MISOEN=0, ROMRD=0, ROMADDR=0, LASTCMD=8'h00, ACTIVE=0, state=IDLE, bit counter=0.
- Deassertion: synchronised nCS going high in any state forces IDLE, MISOEN=0 and ACTIVE=0 on the next MCLK. Partial bytes are discarded.
- States:
  - IDLE: synchronised nCS falling -> CMD with bit counter cleared.
  - CMD: shift 8 bits. After the 8th rise, latch LASTCMD.
    - 0x03 -> ADDR.
    - 0x9F -> ID, ACTIVE=1.
    - 0x05 -> STAT, ACTIVE=1.
    - 0x0B -> ADDR, only with FAST_READ_EN; otherwise treated as an unknown command.
    - Any other command -> IGNORE.
  - ADDR: shift 24 bits MSB first. On the 24th rise:
    - 0x03: issue ROMRD with ROMADDR=addr[ADDR_WIDTH-1:0], go to DATA, ACTIVE=1.
    - 0x0B: go to DUMMY.
  - DUMMY: count 8 rises. On the 8th rise, issue ROMRD and go to DATA, ACTIVE=1.
  - DATA:
    - Capture ROMDATA into the shift register 1 MCLK after ROMRD.
    - On each fall event, set MISOEN=1 and drive the next bit.
    - On the 4th rise of each byte, increment ROMADDR modulo 2^ADDR_WIDTH and issue ROMRD to prefetch. The prefetched byte is loaded on the fall following the 8th rise.
    - Streaming continues until nCS goes high. Address wrap from all-ones to 0 is seamless.
  - ID: stream JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 continuously.
  - STAT: stream 8'h00 continuously (never busy, no write enable).
  - IGNORE: MISOEN stays 0 and MOSI is ignored until nCS goes high.
- The first output bit of any response is driven on the fall event following the last command/address/dummy rise.
- Simultaneous events: a rise and nCS deassertion in the same MCLK -> deassertion wins.
- RST mid-transfer takes priority over everything and returns all outputs to their reset values in the same cycle.

Optional Feature:
- FAST_READ_EN: when defined, command 0x0B (fast read) is decoded: 24 address bits, then 8 dummy clocks, then a data stream identical to 0x03.
- When not defined, 0x0B goes to IGNORE and the DUMMY state and its counter are not synthesised.

Decomposition:
- Shared package spi_flash_pkg holds:
  - command constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_RDSR1=8'h05, CMD_JEDEC=8'h9F;
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE);
  - ADDR_BITS=24 and DUMMY_BITS=8.
- One sub-module, spi_input_sync: the 2-flop synchronisers plus rise/fall event pulse generation. The FSM, shift registers and ROM prefetch stay in the top.

Test Plan:
- Read: ROM[0x3FA]=0xA5, ROM[0x3FB]=0x3C; send 03 00 03 FA, then clock 16 bits -> MISO bytes 0xA5, 0x3C; ROMADDR sequence 0x3FA, 0x3FB, 0x3FC; LASTCMD=0x03.
- Wrap: read from 24'h007FFF with ADDR_WIDTH=15 -> bytes ROM[0x7FFF], ROM[0x0000], ROM[0x0001] with no gap.
- JEDEC: send 9F, clock 32 bits -> EF 40 16 00; ACTIVE=1 throughout; after nCS high, MISOEN=0 within 3 MCLK.
- Unknown/status: send 0xAB -> MISOEN stays 0 and ROMRD is never pulsed. Send 05 with 16 clocks -> 00 00.
- Abort: raise nCS after 12 address bits, then issue a fresh 03 00 00 10 -> correct ROM[0x10] returned with no residue from the aborted frame. Assert RST mid-DATA -> all outputs at reset values the next MCLK.
- FAST_READ_EN: 0B 00 01 00 + 8 dummy clocks -> ROM[0x100] first. With the macro undefined, the same stimulus -> MISOEN=0.
